async_mmap_write_split: RTL and testbench

Next-generation write path for the async memory-mapped channel. It accepts pre-formed burst requests (address plus beat count), splits them at AXI 4 KB boundaries and at a parametrised maximum burst length, and caps the number of outstanding AW transactions. It generates WLAST internally, counts B responses, and returns one completion per original request to the user. It sits between the burst detector/user logic and the m_axi write channels.

---
 rtl/async_mmap_write_split.sv | 245 ++++++++++++++++++++++++
 tb/tb_async_mmap_write_split.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_mmap_write_split.sv
// rtl/async_mmap_write_split.sv - AXI write path: splits bursts at 4 KB and max length, caps outstanding AW, tracks completions
// Small first-word-fall-through FIFO used for the data, length, track and completion queues.
module async_mmap_write_split_fifo #(
  parameter int Width    = 8,
  parameter int DepthLog = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] din_i,
  input  logic             push_i,
  output logic             full_n_o,
  output logic [Width-1:0] dout_o,
  output logic             empty_n_o,
  input  logic             pop_i
);
  localparam int Depth = 2 ** DepthLog;

  logic [Width-1:0]    mem_q [Depth];
  logic [DepthLog-1:0] wr_ptr_q;
  logic [DepthLog-1:0] rd_ptr_q;
  logic [DepthLog:0]   count_q;
  logic                do_push;
  logic                do_pop;

  assign full_n_o  = (count_q != (DepthLog+1)'(Depth));
  assign empty_n_o = (count_q != '0);
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_push   = push_i && full_n_o;
  assign do_pop    = pop_i && empty_n_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{DepthLog{1'b0}}, do_push} - {{DepthLog{1'b0}}, do_pop};
    end
  end
endmodule

module async_mmap_write_split #(
  parameter int AddrWidth          = 64,
  parameter int DataWidth          = 512,
  parameter int DataWidthBytesLog  = 6,
  parameter int ReqLenWidth        = 16,
  parameter int MaxBurstLen        = 64,
  parameter int OutstandingLog     = 4,
  parameter int DataBufferDepthLog = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AddrWidth-1:0]     req_addr_din,
  input  logic [ReqLenWidth-1:0]   req_len_din,
  input  logic                     req_write,
  output logic                     req_full_n,
  input  logic [DataWidth-1:0]     write_data_din,
  input  logic                     write_data_write,
  output logic                     write_data_full_n,
  output logic [ReqLenWidth:0]     write_resp_dout,
  output logic                     write_resp_empty_n,
  input  logic                     write_resp_read,
  output logic                     m_axi_AWVALID,
  input  logic                     m_axi_AWREADY,
  output logic [AddrWidth-1:0]     m_axi_AWADDR,
  output logic [7:0]               m_axi_AWLEN,
  output logic [2:0]               m_axi_AWSIZE,
  output logic [1:0]               m_axi_AWBURST,
  output logic                     m_axi_WVALID,
  input  logic                     m_axi_WREADY,
  output logic [DataWidth-1:0]     m_axi_WDATA,
  output logic [DataWidth/8-1:0]   m_axi_WSTRB,
  output logic                     m_axi_WLAST,
  input  logic                     m_axi_BVALID,
  output logic                     m_axi_BREADY,
  input  logic [1:0]               m_axi_BRESP,
  output logic [OutstandingLog:0]  outstanding,
  output logic                     error
);
  localparam int RemWidth   = ReqLenWidth + 1;
  localparam int CalcWidth  = (RemWidth > 13) ? RemWidth : 13;
  localparam int TrackWidth = RemWidth + 1;
  localparam logic [CalcWidth-1:0]        MaxBurstV = CalcWidth'(MaxBurstLen);
  localparam logic [OutstandingLog+1:0]   MaxOutV   = (OutstandingLog+2)'(2 ** OutstandingLog);
  localparam logic [OutstandingLog:0]     OutOne    = (OutstandingLog+1)'(1);
  localparam logic [AddrWidth-1:0]        LowMask   = AddrWidth'((64'd1 << DataWidthBytesLog) - 64'd1);

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                  state_q;
  logic [AddrWidth-1:0]    cur_addr_q;
  logic [RemWidth-1:0]     rem_q;
  logic [RemWidth-1:0]     total_q;
  logic                    aw_valid_q;
  logic [AddrWidth-1:0]    aw_addr_q;
  logic [7:0]              aw_len_q;
  logic [OutstandingLog:0] outstanding_q;
  logic [OutstandingLog:0] outstanding_d;
  logic [7:0]              beat_cnt_q;
  logic                    error_q;

  logic [12:0]             to4k;
  logic [CalcWidth-1:0]    sub;
  logic [RemWidth-1:0]     sub_rem;
  logic [7:0]              burst_len;
  logic [AddrWidth-1:0]    addr_step;
  logic                    last_sub;
  logic [OutstandingLog+1:0] occupancy;
  logic                    aw_hs;
  logic                    aw_load;
  logic                    w_hs;
  logic                    b_hs;

  logic                    len_full_n, len_empty_n;
  logic [7:0]              len_dout;
  logic                    track_full_n, track_empty_n;
  logic [TrackWidth-1:0]   track_dout;
  logic                    track_last;
  logic [RemWidth-1:0]     track_total;
  logic                    data_empty_n;
  logic                    resp_full_n;

  // Beats left before the next 4 KB boundary; the address is kept beat-aligned so this is never 0.
  assign to4k = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> DataWidthBytesLog;

  always_comb begin
    sub = CalcWidth'(rem_q);
    if (MaxBurstV < sub) sub = MaxBurstV;
    if (CalcWidth'(to4k) < sub) sub = CalcWidth'(to4k);
  end

  assign sub_rem   = sub[RemWidth-1:0];
  assign burst_len = 8'(sub - CalcWidth'(1));
  assign addr_step = AddrWidth'(sub) << DataWidthBytesLog;
  assign last_sub  = (rem_q == sub_rem);
  assign occupancy = {1'b0, outstanding_q} + {{(OutstandingLog+1){1'b0}}, aw_valid_q};

  assign aw_hs   = aw_valid_q && m_axi_AWREADY;
  assign aw_load = (state_q == SPLIT) && (!aw_valid_q || aw_hs) && (occupancy < MaxOutV)
                   && len_full_n && track_full_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      total_q    <= '0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
    end else begin
      if (aw_hs) aw_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_write) begin
            cur_addr_q <= req_addr_din & ~LowMask;
            rem_q      <= {1'b0, req_len_din} + RemWidth'(1);
            total_q    <= {1'b0, req_len_din} + RemWidth'(1);
            state_q    <= SPLIT;
          end
        end
        SPLIT: begin
          if (aw_load) begin
            aw_valid_q <= 1'b1;
            aw_addr_q  <= cur_addr_q;
            aw_len_q   <= burst_len;
            cur_addr_q <= cur_addr_q + addr_step;
            rem_q      <= rem_q - sub_rem;
            if (last_sub) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_full_n    = (state_q == IDLE);
  assign m_axi_AWVALID = aw_valid_q;
  assign m_axi_AWADDR  = aw_addr_q;
  assign m_axi_AWLEN   = aw_len_q;
  assign m_axi_AWSIZE  = 3'(DataWidthBytesLog);
  assign m_axi_AWBURST = 2'b01;
  assign m_axi_WSTRB   = '1;

  // Length is queued at AW load, so W beats may run ahead of the AW handshake.
  async_mmap_write_split_fifo #(.Width(8), .DepthLog(OutstandingLog)) u_len_fifo (
    .clk_i(clk), .rst_i(rst),
    .din_i(burst_len), .push_i(aw_load), .full_n_o(len_full_n),
    .dout_o(len_dout), .empty_n_o(len_empty_n), .pop_i(w_hs && m_axi_WLAST)
  );

  async_mmap_write_split_fifo #(.Width(DataWidth), .DepthLog(DataBufferDepthLog)) u_data_fifo (
    .clk_i(clk), .rst_i(rst),
    .din_i(write_data_din), .push_i(write_data_write), .full_n_o(write_data_full_n),
    .dout_o(m_axi_WDATA), .empty_n_o(data_empty_n), .pop_i(w_hs)
  );

  assign m_axi_WVALID = data_empty_n && len_empty_n;
  assign m_axi_WLAST  = (beat_cnt_q == len_dout);
  assign w_hs         = m_axi_WVALID && m_axi_WREADY;

  async_mmap_write_split_fifo #(.Width(TrackWidth), .DepthLog(OutstandingLog)) u_track_fifo (
    .clk_i(clk), .rst_i(rst),
    .din_i({last_sub, total_q}), .push_i(aw_load), .full_n_o(track_full_n),
    .dout_o(track_dout), .empty_n_o(track_empty_n), .pop_i(b_hs)
  );

  assign track_last   = track_dout[RemWidth];
  assign track_total  = track_dout[RemWidth-1:0];
  assign m_axi_BREADY = track_empty_n && (resp_full_n || !track_last);
  assign b_hs         = m_axi_BVALID && m_axi_BREADY;

  async_mmap_write_split_fifo #(.Width(RemWidth), .DepthLog(OutstandingLog)) u_resp_fifo (
    .clk_i(clk), .rst_i(rst),
    .din_i(track_total), .push_i(b_hs && track_last), .full_n_o(resp_full_n),
    .dout_o(write_resp_dout), .empty_n_o(write_resp_empty_n), .pop_i(write_resp_read)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    if (aw_hs && !b_hs) outstanding_d = outstanding_q + OutOne;
    else if (!aw_hs && b_hs) outstanding_d = outstanding_q - OutOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      error_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (w_hs) beat_cnt_q <= m_axi_WLAST ? 8'd0 : beat_cnt_q + 8'd1;
      if (b_hs && (m_axi_BRESP != 2'b00)) error_q <= 1'b1;
    end
  end

  assign outstanding = outstanding_q;
  assign error       = error_q;
endmodule

// File: tb/tb_async_mmap_write_split.sv
// tb/tb_async_mmap_write_split.sv - directed bench for the AXI write splitter
module tb_async_mmap_write_split;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  req_addr_din = '0;
  logic [15:0]  req_len_din = '0;
  logic         req_write = 1'b0;
  logic         req_full_n;
  logic [511:0] write_data_din = '0;
  logic         write_data_write = 1'b0;
  logic         write_data_full_n;
  logic [16:0]  write_resp_dout;
  logic         write_resp_empty_n;
  logic         write_resp_read = 1'b0;
  logic         m_axi_AWVALID;
  logic         m_axi_AWREADY = 1'b1;
  logic [63:0]  m_axi_AWADDR;
  logic [7:0]   m_axi_AWLEN;
  logic [2:0]   m_axi_AWSIZE;
  logic [1:0]   m_axi_AWBURST;
  logic         m_axi_WVALID;
  logic         m_axi_WREADY = 1'b1;
  logic [511:0] m_axi_WDATA;
  logic [63:0]  m_axi_WSTRB;
  logic         m_axi_WLAST;
  logic         m_axi_BVALID;
  logic         m_axi_BREADY;
  logic [1:0]   m_axi_BRESP;
  logic [1:0]   outstanding;
  logic         error;

  int checks = 0;
  int errors = 0;
  int aw_n = 0, w_n = 0, wl_n = 0, b_n = 0, wdata_bad = 0, out_max = 0;
  int b_limit = 1 << 30;
  int err_idx = -1;
  int push_seq = 0;
  logic [63:0] aw_addr_log [256];
  logic [7:0]  aw_len_log [256];
  int          wlast_log [256];
  int awb, wb, wlb, bb, n;

  async_mmap_write_split #(
    .AddrWidth(64), .DataWidth(512), .DataWidthBytesLog(6), .ReqLenWidth(16),
    .MaxBurstLen(16), .OutstandingLog(1), .DataBufferDepthLog(6)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr_din(req_addr_din), .req_len_din(req_len_din), .req_write(req_write),
    .req_full_n(req_full_n),
    .write_data_din(write_data_din), .write_data_write(write_data_write),
    .write_data_full_n(write_data_full_n),
    .write_resp_dout(write_resp_dout), .write_resp_empty_n(write_resp_empty_n),
    .write_resp_read(write_resp_read),
    .m_axi_AWVALID(m_axi_AWVALID), .m_axi_AWREADY(m_axi_AWREADY), .m_axi_AWADDR(m_axi_AWADDR),
    .m_axi_AWLEN(m_axi_AWLEN), .m_axi_AWSIZE(m_axi_AWSIZE), .m_axi_AWBURST(m_axi_AWBURST),
    .m_axi_WVALID(m_axi_WVALID), .m_axi_WREADY(m_axi_WREADY), .m_axi_WDATA(m_axi_WDATA),
    .m_axi_WSTRB(m_axi_WSTRB), .m_axi_WLAST(m_axi_WLAST),
    .m_axi_BVALID(m_axi_BVALID), .m_axi_BREADY(m_axi_BREADY), .m_axi_BRESP(m_axi_BRESP),
    .outstanding(outstanding), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes are logged at the falling edge, i.e. just before the rising edge that completes them.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (m_axi_AWVALID && m_axi_AWREADY) begin
        aw_addr_log[aw_n] = m_axi_AWADDR;
        aw_len_log[aw_n]  = m_axi_AWLEN;
        aw_n++;
      end
      if (m_axi_WVALID && m_axi_WREADY) begin
        if (m_axi_WDATA[31:0] !== w_n[31:0]) wdata_bad++;
        if (m_axi_WLAST) begin
          wlast_log[wl_n] = w_n + 1;
          wl_n++;
        end
        w_n++;
      end
      if (m_axi_BVALID && m_axi_BREADY) b_n++;
      if (int'(outstanding) > out_max) out_max = int'(outstanding);
    end
  end

  // B responder: answers burst k once its AW and WLAST are done, up to b_limit responses.
  initial begin
    m_axi_BVALID = 1'b0;
    m_axi_BRESP  = 2'd0;
    forever begin
      @(posedge clk); #1;
      m_axi_BVALID = !rst && (b_n < b_limit) && (aw_n > b_n) && (wl_n > b_n);
      m_axi_BRESP  = (b_n == err_idx) ? 2'd2 : 2'd0;
    end
  end

  task automatic send_req(input logic [63:0] addr, input logic [15:0] len);
    int k;
    @(posedge clk); #1;
    k = 0;
    while (!req_full_n && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_slot_free", req_full_n, 1);
    req_addr_din = addr;
    req_len_din  = len;
    req_write    = 1'b1;
    @(posedge clk); #1;
    req_write    = 1'b0;
  endtask

  task automatic push_beats(input int cnt);
    @(posedge clk); #1;
    for (int i = 0; i < cnt; i++) begin
      write_data_din   = {16{push_seq}};
      write_data_write = 1'b1;
      @(posedge clk); #1;
      push_seq++;
    end
    write_data_write = 1'b0;
  endtask

  task automatic pop_resp(input string tag, input logic [16:0] exp);
    int k;
    @(negedge clk);
    k = 0;
    while (!write_resp_empty_n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_avail"}, write_resp_empty_n, 1);
    check(tag, write_resp_dout, exp);
    @(posedge clk); #1;
    write_resp_read = 1'b1;
    @(posedge clk); #1;
    write_resp_read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", m_axi_AWVALID, 0);
    check("rst_wvalid", m_axi_WVALID, 0);
    check("rst_bready", m_axi_BREADY, 0);
    check("rst_resp_empty_n", write_resp_empty_n, 0);
    check("rst_req_full_n", req_full_n, 1);
    check("rst_data_full_n", write_data_full_n, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_error", error, 0);
    check("awsize", m_axi_AWSIZE, 6);
    check("awburst", m_axi_AWBURST, 1);
    check("wstrb", m_axi_WSTRB, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b0;

    // 0x0FC0, 4 beats: one beat up to the 4 KB line, then 3 beats.
    awb = aw_n; wb = w_n; wlb = wl_n;
    @(posedge clk); #1;
    req_addr_din = 64'h0FC0;
    req_len_din  = 16'd3;
    req_write    = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b0;
    @(negedge clk);
    check("t1_awvalid_cycle1", m_axi_AWVALID, 0);
    check("t1_req_full_n_busy", req_full_n, 0);
    @(negedge clk);
    check("t1_awvalid_cycle2", m_axi_AWVALID, 1);
    push_beats(4);
    pop_resp("t1_resp", 17'd4);
    check("t1_aw_count", aw_n - awb, 2);
    check("t1_aw0_addr", aw_addr_log[awb], 64'h0FC0);
    check("t1_aw0_len", aw_len_log[awb], 0);
    check("t1_aw1_addr", aw_addr_log[awb+1], 64'h1000);
    check("t1_aw1_len", aw_len_log[awb+1], 2);
    check("t1_wlast0", wlast_log[wlb], wb + 1);
    check("t1_wlast1", wlast_log[wlb+1], wb + 4);

    // 40 beats from 0 with 16-beat bursts.
    awb = aw_n; wb = w_n; wlb = wl_n;
    send_req(64'h0, 16'd39);
    push_beats(40);
    pop_resp("t2_resp", 17'd40);
    check("t2_aw_count", aw_n - awb, 3);
    check("t2_aw0_addr", aw_addr_log[awb], 64'h0);
    check("t2_aw1_addr", aw_addr_log[awb+1], 64'h400);
    check("t2_aw2_addr", aw_addr_log[awb+2], 64'h800);
    check("t2_aw0_len", aw_len_log[awb], 15);
    check("t2_aw1_len", aw_len_log[awb+1], 15);
    check("t2_aw2_len", aw_len_log[awb+2], 7);
    check("t2_wlast0", wlast_log[wlb], wb + 16);
    check("t2_wlast1", wlast_log[wlb+1], wb + 32);
    check("t2_wlast2", wlast_log[wlb+2], wb + 40);

    // Outstanding cap of 2 with B withheld.
    awb = aw_n; wb = w_n; wlb = wl_n;
    b_limit = b_n;
    send_req(64'h10000, 16'd47);
    push_beats(48);
    n = 0;
    while (w_n - wb < 32 && n < 500) begin @(posedge clk); n++; end
    repeat (10) @(posedge clk);
    check("t3_w_beats", w_n - wb, 32);
    check("t3_aw_count_capped", aw_n - awb, 2);
    @(negedge clk);
    check("t3_outstanding_full", outstanding, 2);
    check("t3_awvalid_held", m_axi_AWVALID, 0);
    check("t3_wvalid_held", m_axi_WVALID, 0);
    b_limit = b_n + 1;
    n = 0;
    while (aw_n - awb < 3 && n < 200) begin @(posedge clk); n++; end
    check("t3_aw_count_after_b", aw_n - awb, 3);
    check("t3_aw2_addr", aw_addr_log[awb+2], 64'h10800);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t3_outstanding_refill", outstanding, 2);
    b_limit = 1 << 30;
    pop_resp("t3_resp", 17'd48);

    // AW and B handshakes in the same cycle at outstanding 1.
    awb = aw_n; wlb = wl_n;
    b_limit = b_n;
    m_axi_AWREADY = 1'b0;
    send_req(64'h20000, 16'd31);
    push_beats(32);
    @(negedge clk);
    n = 0;
    while (!m_axi_AWVALID && n < 100) begin @(negedge clk); n++; end
    check("t4_awvalid_wait", m_axi_AWVALID, 1);
    @(posedge clk); #1;
    m_axi_AWREADY = 1'b1;
    @(posedge clk); #1;
    m_axi_AWREADY = 1'b0;
    n = 0;
    while (wl_n - wlb < 2 && n < 200) begin @(posedge clk); n++; end
    check("t4_wlast_count", wl_n - wlb, 2);
    @(negedge clk);
    check("t4_outstanding_one", outstanding, 1);
    check("t4_aw_pending", m_axi_AWVALID, 1);
    b_limit = b_n + 1;
    @(posedge clk); #1;
    m_axi_AWREADY = 1'b1;
    @(negedge clk);
    check("t4_aw_hs", m_axi_AWVALID && m_axi_AWREADY, 1);
    check("t4_b_hs", m_axi_BVALID && m_axi_BREADY, 1);
    check("t4_outstanding_before", outstanding, 1);
    @(negedge clk);
    check("t4_outstanding_after", outstanding, 1);
    b_limit = 1 << 30;
    pop_resp("t4_resp", 17'd32);

    // Completion FIFO full: non-last B accepted, last B stalls.
    bb = b_n;
    send_req(64'h4000, 16'd0);
    push_beats(1);
    send_req(64'h5000, 16'd0);
    push_beats(1);
    n = 0;
    while (b_n - bb < 2 && n < 200) begin @(posedge clk); n++; end
    check("t6_two_b", b_n - bb, 2);
    send_req(64'h6FC0, 16'd1);
    push_beats(2);
    n = 0;
    while (b_n - bb < 3 && n < 200) begin @(posedge clk); n++; end
    repeat (10) @(posedge clk);
    check("t6_nonlast_b_taken", b_n - bb, 3);
    @(negedge clk);
    check("t6_bvalid_pending", m_axi_BVALID, 1);
    check("t6_bready_blocked", m_axi_BREADY, 0);
    pop_resp("t6_resp_a", 17'd1);
    n = 0;
    while (b_n - bb < 4 && n < 200) begin @(posedge clk); n++; end
    check("t6_last_b_taken", b_n - bb, 4);
    pop_resp("t6_resp_b", 17'd1);
    pop_resp("t6_resp_c", 17'd2);

    // SLVERR response sets the sticky error flag.
    @(negedge clk);
    check("t5_error_before", error, 0);
    err_idx = b_n;
    send_req(64'h3000, 16'd0);
    push_beats(1);
    pop_resp("t5_resp", 17'd1);
    @(negedge clk);
    check("t5_error_set", error, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_error_sticky", error, 1);

    check("wdata_order_errors", wdata_bad, 0);
    check("outstanding_peak", out_max, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
